// File: rtl/mux2_if.sv
// Signal bundle for the 2:1 mux data path: both inputs, the select line
// and the combinational and registered results.
interface mux2_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             sel;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] z_q;

    // Driver side: supplies data and select, observes both results.
    modport master (
        output d0,
        output d1,
        output sel,
        input  z,
        input  z_q
    );

    // Mux side: consumes data and select, produces both results.
    modport slave (
        input  d0,
        input  d1,
        input  sel,
        output z,
        output z_q
    );
endinterface

// File: rtl/mux2.sv
// 2:1 multiplexer with a combinational result z and a one-cycle
// registered copy z_q. Reset clears only the register; z never depends
// on clk or rst.
module mux2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_q
);

    logic [WIDTH-1:0] z_d;

    // Bitwise select; the conditional operator keeps per-bit merging of
    // d0/d1 when sel is unknown in simulation, unlike an if/else.
    always_comb begin
        z_d = '0;
        z_d = sel ? d1 : d0;
    end

    assign z = z_d;

    // Registered copy of the mux result, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= '0;
        end else begin
            z_q <= z_d;
        end
    end

endmodule

// File: tb/tb_mux2.sv
// Self-checking bench for mux2: directed truth table, clockless select
// toggling, reset behaviour, WIDTH=8 case and randomized traffic checked
// against a bitwise reference model.
module tb_mux2;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst    = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mux2_if #(.WIDTH(1)) if1 ();
    mux2_if #(.WIDTH(8)) if8 ();

    mux2 u_dut1 (
        .clk (clk),
        .rst (rst),
        .d0  (if1.d0),
        .d1  (if1.d1),
        .sel (if1.sel),
        .z   (if1.z),
        .z_q (if1.z_q)
    );

    mux2 #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .d0  (if8.d0),
        .d1  (if8.d1),
        .sel (if8.sel),
        .z   (if8.z),
        .z_q (if8.z_q)
    );

    // Gateable free-running clock, period 10; stops in whatever level it holds.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: each result bit is d1 where sel is set, d0 otherwise.
    function automatic logic [7:0] ref_mux(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] m;
        m = {8{s}};
        return (a & ~m) | (b & m);
    endfunction

    initial begin : stim
        logic [2:0]  combo [8];
        logic        exp_tab [8];
        logic [7:0]  exp_q1;
        logic [7:0]  exp_q8;
        logic [7:0]  hold_q;
        logic [7:0]  z_before;

        combo   = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
        exp_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        if1.d0 = '0; if1.d1 = '0; if1.sel = 1'b0;
        if8.d0 = '0; if8.d1 = '0; if8.sel = 1'b0;

        // Reset state
        #1;
        check("reset_zq1", {7'd0, if1.z_q}, 8'h00);
        check("reset_zq8", if8.z_q, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Truth table, each combination held 36 time units (d0,d1,sel)
        for (int i = 0; i < 8; i++) begin
            if1.d0  = combo[i][2];
            if1.d1  = combo[i][1];
            if1.sel = combo[i][0];
            #18;
            check($sformatf("table_%0d", i), {7'd0, if1.z}, {7'd0, exp_tab[i]});
            #18;
        end

        // Select toggling with the clock stopped
        @(negedge clk);
        clk_en = 1'b0;
        if1.d0 = 1'b1; if1.d1 = 1'b0; if1.sel = 1'b0;
        #3;
        hold_q = {7'd0, if1.z_q};
        check("noclk_sel0", {7'd0, if1.z}, 8'h01);
        if1.sel = 1'b1;
        #3;
        check("noclk_sel1", {7'd0, if1.z}, 8'h00);
        if1.sel = 1'b0;
        #3;
        check("noclk_sel0b", {7'd0, if1.z}, 8'h01);
        check("noclk_zq_hold", {7'd0, if1.z_q}, hold_q);
        clk_en = 1'b1;

        // Unknown select merges agreeing bits (only meaningful on 4-state sims)
        if1.d0 = 1'b1; if1.d1 = 1'b1; if1.sel = 1'bx;
        #1;
        if ($isunknown(if1.sel)) begin
            check("selx_agree", {7'd0, if1.z}, 8'h01);
            if1.d0 = 1'b0;
            #1;
            check("selx_differ", {7'd0, if1.z}, {7'd0, 1'bx});
        end
        if1.sel = 1'b0;

        // Registered copy then asynchronous reset between edges
        @(negedge clk);
        if1.d0 = 1'b1; if1.d1 = 1'b0; if1.sel = 1'b0;
        @(posedge clk);
        #1;
        check("zq_after_edge", {7'd0, if1.z_q}, 8'h01);
        #1;
        rst = 1'b1;
        #1;
        check("zq_async_rst", {7'd0, if1.z_q}, 8'h00);
        check("z_during_rst", {7'd0, if1.z}, 8'h01);
        if1.sel = 1'b1;
        #1;
        check("z_follows_in_rst", {7'd0, if1.z}, 8'h00);
        if1.sel = 1'b0;
        @(negedge clk);
        check("zq_held_in_rst", {7'd0, if1.z_q}, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("zq_resume", {7'd0, if1.z_q}, 8'h01);

        // WIDTH=8 directed case
        @(negedge clk);
        if8.d0 = 8'hA5; if8.d1 = 8'h3C; if8.sel = 1'b1;
        #1;
        check("w8_z", if8.z, 8'h3C);
        @(posedge clk);
        #1;
        check("w8_zq", if8.z_q, 8'h3C);

        // Randomized traffic with occasional mid-cycle reset pulses
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if1.d0  = 1'($urandom);
            if1.d1  = 1'($urandom);
            if1.sel = 1'($urandom);
            if8.d0  = 8'($urandom);
            if8.d1  = 8'($urandom);
            if8.sel = 1'($urandom);
            #1;
            check("rnd_z1", {7'd0, if1.z}, ref_mux({7'd0, if1.d0}, {7'd0, if1.d1}, if1.sel));
            check("rnd_z8", if8.z, ref_mux(if8.d0, if8.d1, if8.sel));
            if ($urandom_range(0, 7) == 0) begin
                z_before = if8.z;
                rst = 1'b1;
                #1;
                check("rnd_rst_zq1", {7'd0, if1.z_q}, 8'h00);
                check("rnd_rst_zq8", if8.z_q, 8'h00);
                check("rnd_rst_z8", if8.z, z_before);
                rst = 1'b0;
            end
            exp_q1 = ref_mux({7'd0, if1.d0}, {7'd0, if1.d1}, if1.sel);
            exp_q8 = ref_mux(if8.d0, if8.d1, if8.sel);
            @(posedge clk);
            #1;
            check("rnd_zq1", {7'd0, if1.z_q}, exp_q1);
            check("rnd_zq8", if8.z_q, exp_q8);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux2.md
MUX2 -- requirements
Module: mux2

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter WIDTH, default 1: bit width of d0, d1, z and z_q.
REQ-003 Port clk, input, 1: rising-edge clock for the registered output only.
REQ-004 Port rst, input, 1: asynchronous, active-high reset of the registered output.
REQ-005 Port d0, input, WIDTH: data input selected when sel=0.
REQ-006 Port d1, input, WIDTH: data input selected when sel=1.
REQ-007 Port sel, input, 1: select line.
REQ-008 Port z, output, WIDTH: combinational mux result.
REQ-009 Port z_q, output, WIDTH: registered copy of z.

Function
REQ-010 z SHALL equal d0 when sel=0 and d1 when sel=1.
REQ-011 z SHALL be purely combinational: zero latency, no dependence on clk or rst.
REQ-012 Any change on d0, d1 or sel SHALL propagate to z within the same delta-settled time step.
REQ-013 With sel=X or Z in simulation, z SHALL take, per bit, the common value where d0 and d1 bits agree, and X where they differ.
REQ-014 z SHALL be a bitwise selection only: no arithmetic, no width extension, and no truncation beyond WIDTH.
REQ-015 z_q SHALL load z on every rising clk edge while rst=0, giving a latency of 1 cycle.
REQ-016 With clk unconnected or static, z SHALL still operate correctly; z_q then holds its last value.
REQ-017 The block SHALL contain no state other than the z_q register.

Reset
REQ-018 Asserting rst SHALL force z_q to all-zeros immediately, independent of clk.
REQ-019 z_q SHALL stay at zero while rst=1.
REQ-020 After rst deasserts, z_q SHALL resume loading z from the next rising clk edge.
REQ-021 rst SHALL have no effect on z.
REQ-022 If rst asserts in the middle of operation, z SHALL continue to follow sel without interruption.

Structure
REQ-023 The block SHALL need no shared package; WIDTH is a local parameter of mux2.
REQ-024 The block SHALL be one flat module with no sub-modules: one combinational select plus one register.

Verification
REQ-025 Bench SHALL hold each of the eight combinations for 36 time units, in this order: (d0,d1,sel) = 000, 100, 010, 110, 001, 101, 011, 111.
REQ-026 Required z for that sequence, in order: 0, 1, 0, 1, 0, 0, 1, 1.
REQ-027 Stimulus d0=1, d1=0, sel toggled 0->1->0 -> z goes 1->0->1 with no clock edge applied.
REQ-028 Stimulus sel=X with d0=d1=1 -> z=1; sel=X with d0=0, d1=1 -> z=X.
REQ-029 Stimulus z=1, then a rising clk edge, then rst pulsed high between edges -> z_q=1 after the edge, z_q=0 as soon as rst rises, and z unchanged.
REQ-030 Stimulus WIDTH=8, d0=8'hA5, d1=8'h3C, sel=1 -> z=8'h3C immediately and z_q=8'h3C after the next rising clk edge.
